bpf_axil_regs: RTL and testbench
================================

Name: bpf_axil_regs

Overview:
- AXI4-Lite slave register file for BPF code loading and control.
- Turns host writes into single-cycle value/strobe pairs (inst_high, inst_low, control_start) for the code-memory writer stage directly downstream.
- Provides a status register and a count of instruction words loaded so the host can verify a program download.

Parameters:
- ADDR_WIDTH, 4: AXI address width in bits; only addr[3:2] is decoded.
- CNT_WIDTH, 11: width of the instruction-load counter; must hold 0..1024.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- s_axil_awaddr  in  ADDR_WIDTH  write address
- s_axil_awvalid  in  1  write-address valid
- s_axil_awready  out  1  write-address ready
- s_axil_wdata  in  32  write data
- s_axil_wstrb  in  4  write byte strobes
- s_axil_wvalid  in  1  write-data valid
- s_axil_wready  out  1  write-data ready
- s_axil_bresp  out  2  write response (00 OKAY, 10 SLVERR)
- s_axil_bvalid  out  1  write-response valid
- s_axil_bready  in  1  write-response ready
- s_axil_araddr  in  ADDR_WIDTH  read address
- s_axil_arvalid  in  1  read-address valid
- s_axil_arready  out  1  read-address ready
- s_axil_rdata  out  32  read data
- s_axil_rresp  out  2  read response
- s_axil_rvalid  out  1  read-data valid
- s_axil_rready  in  1  read-data ready
- inst_high_value  out  32  last accepted INST_HIGH word
- inst_high_strobe  out  1  one-cycle pulse when INST_HIGH is written
- inst_low_value  out  32  last accepted INST_LOW word
- inst_low_strobe  out  1  one-cycle pulse when INST_LOW is written
- control_start  out  1  one-cycle pulse on CONTROL write with bit0=1
- running  in  1  filter-running status from the core

Behaviour:
- Reset (rst_n low, asynchronous): every output is 0, including all *ready, *valid, *_value, strobes and rdata. Counter and latches clear. A transaction in flight during reset is dropped and gets no response.
- Register map (addr[3:2]):
  - 0 CONTROL: W bit0 = start; R returns 0.
  - 1 INST_HIGH: W only.
  - 2 INST_LOW: W only.
  - 3 STATUS: R only; bit0 = running, bits[16+CNT_WIDTH-1:16] = load counter.
- Write channel: AW and W are latched independently.
  - awready = no AW latched and bvalid low. wready = no W latched and bvalid low.
  - The write executes in the cycle after both are latched. Latches then clear, bvalid rises, and bvalid holds until bready.
  - No new AW or W is accepted while bvalid is high.
- Write validity: wstrb must be 4'hF and the address must be writable. Otherwise bresp = SLVERR with no strobe and no state change.
  - A CONTROL write with bit0=0 is OKAY with no pulse.
- Strobe timing: on the execute cycle, the selected *_value register loads wdata and its strobe is high for exactly that one cycle. The value is stable from that cycle until the next write to the same register.
- Load counter: increments on each inst_low_strobe and saturates at 2^CNT_WIDTH-1. The control_start pulse clears it to 0 in the same cycle.
- Read channel:
  - arready = !rvalid. An AR handshake registers rdata/rresp and sets rvalid the next cycle.
  - rvalid and rdata hold until rready.
  - Reads of INST_HIGH or INST_LOW return 0 with SLVERR (but see optional feature).
- Reads and writes are independent. A same-cycle STATUS read and INST_LOW write returns the counter value from before the increment.

Optional Feature:
- Macro BPF_REGS_READBACK_EN.
- Defined: reads of INST_HIGH and INST_LOW return inst_high_value / inst_low_value with OKAY.
- Undefined: those reads return 0 with SLVERR, and no readback mux is synthesised.

Decomposition:
- Shared package bpf_regs_pkg holds:
  - register offsets: REG_CONTROL=0, REG_INST_HIGH=1, REG_INST_LOW=2, REG_STATUS=3
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - STATUS field positions
- One natural sub-module, axil_wr_capture: holds the AW/W latches and B handshake, and outputs a one-cycle write-execute pulse with address, data and wstrb.

Test Plan:
- Reset release, then write INST_HIGH=0xDEADBEEF followed by INST_LOW=0x00000006 → one pulse on each strobe; values held; bresp OKAY; STATUS reads 0x00010000.
- W presented 3 cycles before AW, with bready held low for 4 cycles → exactly one strobe pulse; awready/wready stay low until bready; only one B response.
- Write CONTROL=1 after loading 5 INST_LOW words → control_start pulses for one cycle; STATUS counter reads 0.
- Write INST_LOW with wstrb=4'h3, and write to STATUS → SLVERR for both; no strobes; counter unchanged.
- Assert rst_n low mid-write (AW latched, W pending) → all outputs 0 immediately; after release, a fresh write completes normally.
- Read INST_LOW after writing 0x12345678 → 0x12345678/OKAY with BPF_REGS_READBACK_EN defined; 0/SLVERR without it.

Source files
------------

// File: rtl/bpf_regs_pkg.sv
// Shared definitions for the BPF AXI4-Lite register block.
// Holds register offsets, AXI response codes, STATUS field positions,
// the write-command payload struct and the write-legality helper.
package bpf_regs_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned STRB_W    = DATA_W / 8;
  localparam int unsigned REG_IDX_W = 2;

  // Word index decoded from addr[3:2]
  typedef enum logic [REG_IDX_W-1:0] {
    REG_CONTROL   = 2'd0,
    REG_INST_HIGH = 2'd1,
    REG_INST_LOW  = 2'd2,
    REG_STATUS    = 2'd3
  } reg_idx_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned STATUS_RUNNING_BIT = 0;
  localparam int unsigned STATUS_CNT_LSB     = 16;

  // Captured write: register index, data and byte strobes
  typedef struct packed {
    reg_idx_e              idx;
    logic [DATA_W-1:0]     data;
    logic [STRB_W-1:0]     strb;
  } wr_cmd_t;

  // Only full-word writes to a writable register are accepted
  function automatic logic wr_allowed(input wr_cmd_t cmd);
    return (cmd.strb == '1) && (cmd.idx != REG_STATUS);
  endfunction

endpackage

// File: rtl/axil_wr_capture.sv
// AXI4-Lite write-channel capture.
// Latches AW and W independently, issues a one-cycle execute pulse once both
// are held, then returns a B response and holds it until bready.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   s_axil_aw*/w*/b*        AXI4-Lite write address/data/response channels
//   exec_c                  high for the single cycle the latched write executes
//   cmd                     latched register index, data and strobes
module axil_wr_capture
  import bpf_regs_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_W-1:0]     s_axil_wdata,
  input  logic [STRB_W-1:0]     s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  output logic                  exec_c,
  output wr_cmd_t               cmd
);

  logic              aw_lat_q, aw_lat_d;
  reg_idx_e          aw_idx_q, aw_idx_d;
  logic              w_lat_q, w_lat_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              bvalid_d;
  logic [1:0]        bresp_d;
  logic              awready_d, wready_d;

  // Only addr[3:2] selects a register; the rest is ignored
  logic unused_awaddr;
  assign unused_awaddr = ^s_axil_awaddr;

  assign cmd = '{idx: aw_idx_q, data: wdata_q, strb: wstrb_q};

  // Latch / execute / response next-state
  always_comb begin
    aw_lat_d = aw_lat_q;
    aw_idx_d = aw_idx_q;
    w_lat_d  = w_lat_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    bvalid_d = s_axil_bvalid;
    bresp_d  = s_axil_bresp;
    exec_c   = aw_lat_q && w_lat_q;

    if (exec_c) begin
      aw_lat_d = 1'b0;
      w_lat_d  = 1'b0;
      bvalid_d = 1'b1;
      bresp_d  = wr_allowed(cmd) ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (s_axil_awvalid && s_axil_awready) begin
        aw_lat_d = 1'b1;
        aw_idx_d = reg_idx_e'(s_axil_awaddr[3:2]);
      end
      if (s_axil_wvalid && s_axil_wready) begin
        w_lat_d = 1'b1;
        wdata_d = s_axil_wdata;
        wstrb_d = s_axil_wstrb;
      end
      if (s_axil_bvalid && s_axil_bready) begin
        bvalid_d = 1'b0;
      end
    end

    // Ready flops track "nothing latched and no response pending"
    awready_d = !aw_lat_d && !bvalid_d;
    wready_d  = !w_lat_d && !bvalid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_lat_q       <= 1'b0;
      aw_idx_q       <= REG_CONTROL;
      w_lat_q        <= 1'b0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      s_axil_bvalid  <= 1'b0;
      s_axil_bresp   <= RESP_OKAY;
      s_axil_awready <= 1'b0;
      s_axil_wready  <= 1'b0;
    end else begin
      aw_lat_q       <= aw_lat_d;
      aw_idx_q       <= aw_idx_d;
      w_lat_q        <= w_lat_d;
      wdata_q        <= wdata_d;
      wstrb_q        <= wstrb_d;
      s_axil_bvalid  <= bvalid_d;
      s_axil_bresp   <= bresp_d;
      s_axil_awready <= awready_d;
      s_axil_wready  <= wready_d;
    end
  end

endmodule

// File: rtl/bpf_axil_regs.sv
// AXI4-Lite register file for BPF code loading and control.
// Converts host writes into value/strobe pairs for the code-memory writer,
// exposes a STATUS register with the running flag and instruction-load count.
// Optional: define BPF_REGS_READBACK_EN to make INST_HIGH/INST_LOW readable.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   s_axil_*                      AXI4-Lite slave interface
//   inst_high_value/_strobe       last INST_HIGH word and its write pulse
//   inst_low_value/_strobe        last INST_LOW word and its write pulse
//   control_start                 pulse on CONTROL write with bit0 set
//   running                       filter-running status from the core
module bpf_axil_regs
  import bpf_regs_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned CNT_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [31:0]           s_axil_wdata,
  input  logic [3:0]            s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [31:0]           s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic [31:0]           inst_high_value,
  output logic                  inst_high_strobe,
  output logic [31:0]           inst_low_value,
  output logic                  inst_low_strobe,
  output logic                  control_start,
  input  logic                  running
);

  logic                 wr_exec_c;
  wr_cmd_t              wr_cmd;
  logic                 wr_ok_c;
  logic [CNT_WIDTH-1:0] load_cnt;

  axil_wr_capture #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_wr_capture (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_axil_awaddr  (s_axil_awaddr),
    .s_axil_awvalid (s_axil_awvalid),
    .s_axil_awready (s_axil_awready),
    .s_axil_wdata   (s_axil_wdata),
    .s_axil_wstrb   (s_axil_wstrb),
    .s_axil_wvalid  (s_axil_wvalid),
    .s_axil_wready  (s_axil_wready),
    .s_axil_bresp   (s_axil_bresp),
    .s_axil_bvalid  (s_axil_bvalid),
    .s_axil_bready  (s_axil_bready),
    .exec_c         (wr_exec_c),
    .cmd            (wr_cmd)
  );

  assign wr_ok_c = wr_exec_c && wr_allowed(wr_cmd);

  // Register updates, strobes and load counter (start wins the clear)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_high_value  <= '0;
      inst_high_strobe <= 1'b0;
      inst_low_value   <= '0;
      inst_low_strobe  <= 1'b0;
      control_start    <= 1'b0;
      load_cnt         <= '0;
    end else begin
      inst_high_strobe <= 1'b0;
      inst_low_strobe  <= 1'b0;
      control_start    <= 1'b0;
      if (wr_ok_c) begin
        unique case (wr_cmd.idx)
          REG_CONTROL: begin
            if (wr_cmd.data[0]) begin
              control_start <= 1'b1;
              load_cnt      <= '0;
            end
          end
          REG_INST_HIGH: begin
            inst_high_value  <= wr_cmd.data;
            inst_high_strobe <= 1'b1;
          end
          REG_INST_LOW: begin
            inst_low_value  <= wr_cmd.data;
            inst_low_strobe <= 1'b1;
            if (load_cnt != '1) begin
              load_cnt <= load_cnt + CNT_WIDTH'(1);
            end
          end
          REG_STATUS: ;
        endcase
      end
    end
  end

  logic        ar_hs_c;
  logic        rvalid_d;
  logic [31:0] rd_data_c;
  logic [1:0]  rd_resp_c;

  assign ar_hs_c = s_axil_arvalid && s_axil_arready;

  logic unused_araddr;
  assign unused_araddr = ^s_axil_araddr;

  // Read decode; sampled only on an AR handshake
  always_comb begin
    rd_data_c = '0;
    rd_resp_c = RESP_OKAY;
    unique case (reg_idx_e'(s_axil_araddr[3:2]))
      REG_CONTROL: ;
`ifdef BPF_REGS_READBACK_EN
      REG_INST_HIGH: rd_data_c = inst_high_value;
      REG_INST_LOW:  rd_data_c = inst_low_value;
`else
      REG_INST_HIGH: rd_resp_c = RESP_SLVERR;
      REG_INST_LOW:  rd_resp_c = RESP_SLVERR;
`endif
      REG_STATUS: begin
        rd_data_c[STATUS_RUNNING_BIT]          = running;
        rd_data_c[STATUS_CNT_LSB +: CNT_WIDTH] = load_cnt;
      end
    endcase
  end

  always_comb begin
    rvalid_d = s_axil_rvalid;
    if (ar_hs_c) begin
      rvalid_d = 1'b1;
    end else if (s_axil_rvalid && s_axil_rready) begin
      rvalid_d = 1'b0;
    end
  end

  // Read channel; arready mirrors !rvalid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_axil_rvalid  <= 1'b0;
      s_axil_arready <= 1'b0;
      s_axil_rdata   <= '0;
      s_axil_rresp   <= RESP_OKAY;
    end else begin
      s_axil_rvalid  <= rvalid_d;
      s_axil_arready <= !rvalid_d;
      if (ar_hs_c) begin
        s_axil_rdata <= rd_data_c;
        s_axil_rresp <= rd_resp_c;
      end
    end
  end

endmodule

// File: tb/tb_bpf_axil_regs.sv
// Self-checking bench for bpf_axil_regs with a behavioural register model.
module tb_bpf_axil_regs;

  localparam int unsigned AW      = 4;
  localparam int unsigned CW      = 11;
  localparam int          CNT_MAX = (1 << CW) - 1;
  localparam logic [1:0]  OK      = 2'b00;
  localparam logic [1:0]  ERR     = 2'b10;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] s_axil_awaddr;
  logic          s_axil_awvalid;
  logic          s_axil_awready;
  logic [31:0]   s_axil_wdata;
  logic [3:0]    s_axil_wstrb;
  logic          s_axil_wvalid;
  logic          s_axil_wready;
  logic [1:0]    s_axil_bresp;
  logic          s_axil_bvalid;
  logic          s_axil_bready;
  logic [AW-1:0] s_axil_araddr;
  logic          s_axil_arvalid;
  logic          s_axil_arready;
  logic [31:0]   s_axil_rdata;
  logic [1:0]    s_axil_rresp;
  logic          s_axil_rvalid;
  logic          s_axil_rready;
  logic [31:0]   inst_high_value;
  logic          inst_high_strobe;
  logic [31:0]   inst_low_value;
  logic          inst_low_strobe;
  logic          control_start;
  logic          running;

  bpf_axil_regs #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
    .s_axil_wready(s_axil_wready), .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid),
    .s_axil_bready(s_axil_bready), .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid),
    .s_axil_arready(s_axil_arready), .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .inst_high_value(inst_high_value), .inst_high_strobe(inst_high_strobe),
    .inst_low_value(inst_low_value), .inst_low_strobe(inst_low_strobe),
    .control_start(control_start), .running(running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observed strobe-high cycles (a stretched pulse shows up as extra counts)
  int n_high = 0, n_low = 0, n_start = 0;
  // Protocol anomalies seen inside the bus tasks
  int timeouts = 0, bad_ready = 0, extra_b = 0, hold_bad = 0;

  // Reference model
  int          e_high = 0, e_low = 0, e_start = 0;
  int          m_cnt  = 0;
  logic [31:0] m_high = '0, m_low = '0;

  logic [107:0] all_outs;
  assign all_outs = {s_axil_awready, s_axil_wready, s_axil_bresp, s_axil_bvalid, s_axil_arready,
                     s_axil_rdata, s_axil_rresp, s_axil_rvalid, inst_high_value, inst_high_strobe,
                     inst_low_value, inst_low_strobe, control_start};

  always @(negedge clk) begin
    if (rst_n) begin
      if (inst_high_strobe) n_high++;
      if (inst_low_strobe)  n_low++;
      if (control_start)    n_start++;
    end
  end

  function automatic void model_reset();
    m_cnt  = 0;
    m_high = '0;
    m_low  = '0;
  endfunction

  function automatic logic [1:0] model_write(input logic [3:0] addr, input logic [31:0] data,
                                             input logic [3:0] strb);
    int idx;
    idx = int'(addr[3:2]);
    if (strb != 4'hF || idx == 3) return ERR;
    if (idx == 0) begin
      if (data[0]) begin
        e_start++;
        m_cnt = 0;
      end
    end else if (idx == 1) begin
      m_high = data;
      e_high++;
    end else begin
      m_low = data;
      e_low++;
      if (m_cnt < CNT_MAX) m_cnt++;
    end
    return OK;
  endfunction

  function automatic void model_read(input logic [3:0] addr, input logic run,
                                     output logic [31:0] d, output logic [1:0] r);
    int idx;
    idx = int'(addr[3:2]);
    d = '0;
    r = OK;
    if (idx == 1 || idx == 2) begin
`ifdef BPF_REGS_READBACK_EN
      d = (idx == 1) ? m_high : m_low;
`else
      r = ERR;
`endif
    end else if (idx == 3) begin
      d = (32'(m_cnt) << 16) | 32'(run);
    end
  endfunction

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly,
                           output logic [1:0] resp);
    bit aw_done, w_done, sa, sw, got;
    int c, wb;
    aw_done = 0; w_done = 0; c = 0; got = 0; wb = 0;
    resp = 2'bxx;
    s_axil_awaddr = addr;
    s_axil_wdata  = data;
    s_axil_wstrb  = strb;
    while (!(aw_done && w_done) && c < 100) begin
      @(negedge clk);
      s_axil_awvalid = !aw_done && (c >= aw_dly);
      s_axil_wvalid  = !w_done && (c >= w_dly);
      sa = s_axil_awready;
      sw = s_axil_wready;
      @(posedge clk);
      if (s_axil_awvalid && sa) aw_done = 1;
      if (s_axil_wvalid && sw)  w_done  = 1;
      c++;
    end
    @(negedge clk);
    s_axil_awvalid = 1'b0;
    s_axil_wvalid  = 1'b0;
    if (!(aw_done && w_done)) begin
      timeouts++;
      return;
    end
    for (int i = 0; i < 100 + b_dly && !got; i++) begin
      if (s_axil_bvalid) begin
        if (wb >= b_dly) begin
          s_axil_bready = 1'b1;
          resp = s_axil_bresp;
          @(posedge clk);
          got = 1;
        end else begin
          if (s_axil_awready || s_axil_wready) bad_ready++;
          wb++;
        end
      end
      @(negedge clk);
    end
    s_axil_bready = 1'b0;
    if (!got) timeouts++;
    else if (s_axil_bvalid) extra_b++;
  endtask

  task automatic axi_read(input logic [3:0] addr, input int r_dly,
                          output logic [31:0] data, output logic [1:0] resp);
    bit done, got, sa;
    int wr;
    logic [31:0] held;
    done = 0; got = 0; wr = 0; held = '0;
    data = 'x; resp = 'x;
    @(negedge clk);
    s_axil_araddr  = addr;
    s_axil_arvalid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      sa = s_axil_arready;
      @(posedge clk);
      if (sa) done = 1;
      else @(negedge clk);
    end
    @(negedge clk);
    s_axil_arvalid = 1'b0;
    if (!done) begin
      timeouts++;
      return;
    end
    for (int i = 0; i < 100 + r_dly && !got; i++) begin
      if (s_axil_rvalid) begin
        if (wr == 0) held = s_axil_rdata;
        else if (s_axil_rdata !== held) hold_bad++;
        if (wr >= r_dly) begin
          s_axil_rready = 1'b1;
          data = s_axil_rdata;
          resp = s_axil_rresp;
          @(posedge clk);
          got = 1;
        end
        wr++;
      end
      @(negedge clk);
    end
    s_axil_rready = 1'b0;
    if (!got) timeouts++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (all_outs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", all_outs);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({s_axil_awready, s_axil_wready, s_axil_arready, s_axil_bvalid, s_axil_rvalid} !== 5'b11100) begin
      errors++;
      $display("FAIL reset_release_ready: got %b expected 11100",
               {s_axil_awready, s_axil_wready, s_axil_arready, s_axil_bvalid, s_axil_rvalid});
    end
  endtask

  task automatic test_basic_load();
    logic [1:0] r, er;
    logic [31:0] d;
    er = model_write(4'h4, 32'hDEADBEEF, 4'hF);
    axi_write(4'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0, r);
    checks++;
    if (r !== er || n_high !== e_high || inst_high_value !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL basic_high: resp %b/%b pulses %0d/%0d value %h/DEADBEEF", r, er, n_high, e_high, inst_high_value);
    end
    er = model_write(4'h8, 32'h00000006, 4'hF);
    axi_write(4'h8, 32'h00000006, 4'hF, 1, 0, 1, r);
    checks++;
    if (r !== er || n_low !== e_low || inst_low_value !== 32'h6 || inst_high_value !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL basic_low: resp %b/%b pulses %0d/%0d low %h high %h", r, er, n_low, e_low, inst_low_value, inst_high_value);
    end
    axi_read(4'hC, 0, d, r);
    checks++;
    if (d !== 32'h00010000 || r !== OK) begin
      errors++;
      $display("FAIL basic_status: got %h/%b expected 00010000/00", d, r);
    end
  endtask

  task automatic test_w_before_aw();
    logic [1:0] r, er;
    bad_ready = 0; extra_b = 0;
    er = model_write(4'h4, 32'hCAFE0001, 4'hF);
    axi_write(4'h4, 32'hCAFE0001, 4'hF, 3, 0, 4, r);
    checks++;
    if (r !== er || n_high !== e_high || inst_high_value !== m_high) begin
      errors++;
      $display("FAIL w_before_aw: resp %b/%b pulses %0d/%0d value %h/%h", r, er, n_high, e_high, inst_high_value, m_high);
    end
    checks++;
    if (bad_ready !== 0 || extra_b !== 0) begin
      errors++;
      $display("FAIL b_hold: ready_while_bvalid %0d extra_b %0d expected 0 0", bad_ready, extra_b);
    end
  endtask

  task automatic test_control_start();
    logic [1:0] r, er;
    logic [31:0] d, ed;
    for (int i = 0; i < 5; i++) begin
      logic [31:0] v;
      v = $urandom;
      er = model_write(4'h8, v, 4'hF);
      axi_write(4'h8, v, 4'hF, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), r);
      checks++;
      if (r !== er || inst_low_value !== v) begin
        errors++;
        $display("FAIL load_word%0d: resp %b/%b value %h/%h", i, r, er, inst_low_value, v);
      end
    end
    running = 1'b1;
    model_read(4'hC, running, ed, er);
    axi_read(4'hC, 1, d, r);
    checks++;
    if (d !== ed || r !== er) begin
      errors++;
      $display("FAIL status_after_load: got %h/%b expected %h/%b", d, r, ed, er);
    end
    er = model_write(4'h0, 32'h0, 4'hF);
    axi_write(4'h0, 32'h0, 4'hF, 0, 0, 0, r);
    checks++;
    if (r !== OK || n_start !== e_start) begin
      errors++;
      $display("FAIL control_zero: resp %b/00 starts %0d/%0d", r, n_start, e_start);
    end
    er = model_write(4'h0, 32'h1, 4'hF);
    axi_write(4'h0, 32'h1, 4'hF, 0, 2, 0, r);
    checks++;
    if (r !== OK || n_start !== e_start) begin
      errors++;
      $display("FAIL control_start: resp %b/00 starts %0d/%0d", r, n_start, e_start);
    end
    axi_read(4'hC, 0, d, r);
    checks++;
    if (d !== 32'h00000001 || r !== OK) begin
      errors++;
      $display("FAIL status_cleared: got %h/%b expected 00000001/00", d, r);
    end
    running = 1'b0;
  endtask

  task automatic test_slverr();
    logic [1:0] r, er;
    logic [31:0] d, ed, low_before;
    int hb, lb;
    hb = n_high; lb = n_low; low_before = inst_low_value;
    er = model_write(4'h8, 32'h5555AAAA, 4'h3);
    axi_write(4'h8, 32'h5555AAAA, 4'h3, 0, 0, 0, r);
    checks++;
    if (r !== ERR || r !== er || n_low !== lb || inst_low_value !== low_before) begin
      errors++;
      $display("FAIL partial_strobe: resp %b/10 pulses %0d/%0d value %h/%h", r, n_low, lb, inst_low_value, low_before);
    end
    er = model_write(4'hC, 32'hFFFFFFFF, 4'hF);
    axi_write(4'hC, 32'hFFFFFFFF, 4'hF, 0, 0, 0, r);
    checks++;
    if (r !== ERR || n_high !== hb || n_low !== lb || n_start !== e_start) begin
      errors++;
      $display("FAIL status_write: resp %b/10 high %0d/%0d low %0d/%0d", r, n_high, hb, n_low, lb);
    end
    model_read(4'hC, running, ed, er);
    axi_read(4'hC, 0, d, r);
    checks++;
    if (d !== ed || r !== er) begin
      errors++;
      $display("FAIL slverr_counter: got %h/%b expected %h/%b", d, r, ed, er);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [1:0] r, er;
    logic [31:0] d;
    @(negedge clk);
    s_axil_awaddr  = 4'h8;
    s_axil_awvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_axil_awvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (all_outs !== '0) begin
      errors++;
      $display("FAIL reset_mid_write: got %h expected 0", all_outs);
    end
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    er = model_write(4'h8, 32'h0000ABCD, 4'hF);
    axi_write(4'h8, 32'h0000ABCD, 4'hF, 0, 1, 0, r);
    checks++;
    if (r !== er || n_low !== e_low || inst_low_value !== 32'h0000ABCD || inst_high_value !== 32'h0) begin
      errors++;
      $display("FAIL post_reset_write: resp %b/%b pulses %0d/%0d low %h high %h", r, er, n_low, e_low, inst_low_value, inst_high_value);
    end
    axi_read(4'hC, 0, d, r);
    checks++;
    if (d !== 32'h00010000 || r !== OK) begin
      errors++;
      $display("FAIL post_reset_status: got %h/%b expected 00010000/00", d, r);
    end
  endtask

  task automatic test_readback();
    logic [1:0] r, er;
    logic [31:0] d, ed;
    er = model_write(4'h8, 32'h12345678, 4'hF);
    axi_write(4'h8, 32'h12345678, 4'hF, 0, 0, 0, r);
    axi_read(4'h8, 2, d, r);
    checks++;
`ifdef BPF_REGS_READBACK_EN
    if (d !== 32'h12345678 || r !== OK) begin
      errors++;
      $display("FAIL readback_low: got %h/%b expected 12345678/00", d, r);
    end
`else
    if (d !== 32'h0 || r !== ERR) begin
      errors++;
      $display("FAIL readback_low: got %h/%b expected 00000000/10", d, r);
    end
`endif
    model_read(4'h4, running, ed, er);
    axi_read(4'h4, 0, d, r);
    checks++;
    if (d !== ed || r !== er) begin
      errors++;
      $display("FAIL readback_high: got %h/%b expected %h/%b", d, r, ed, er);
    end
    axi_read(4'h0, 0, d, r);
    checks++;
    if (d !== 32'h0 || r !== OK) begin
      errors++;
      $display("FAIL read_control: got %h/%b expected 00000000/00", d, r);
    end
  endtask

  task automatic test_random();
    logic [1:0] r, er;
    logic [31:0] d, ed, v;
    logic [3:0] a, s;
    for (int k = 0; k < 60; k++) begin
      a = {2'($urandom), 2'($urandom)};
      if ($urandom_range(0, 2) == 0) begin
        running = 1'($urandom);
        model_read(a, running, ed, er);
        axi_read(a, $urandom_range(0, 3), d, r);
        checks++;
        if (d !== ed || r !== er) begin
          errors++;
          $display("FAIL rand_read%0d addr %h: got %h/%b expected %h/%b", k, a, d, r, ed, er);
        end
      end else begin
        v = $urandom;
        s = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
        er = model_write(a, v, s);
        axi_write(a, v, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), r);
        checks++;
        if (r !== er || n_high !== e_high || n_low !== e_low || n_start !== e_start ||
            inst_high_value !== m_high || inst_low_value !== m_low) begin
          errors++;
          $display("FAIL rand_write%0d addr %h strb %h: resp %b/%b pulses h%0d/%0d l%0d/%0d s%0d/%0d values %h/%h %h/%h",
                   k, a, s, r, er, n_high, e_high, n_low, e_low, n_start, e_start,
                   inst_high_value, m_high, inst_low_value, m_low);
        end
      end
    end
    running = 1'b0;
  endtask

  task automatic test_saturation();
    logic [1:0] r, er;
    logic [31:0] d;
    for (int i = 0; i < CNT_MAX + 3; i++) begin
      er = model_write(4'h8, 32'(i), 4'hF);
      axi_write(4'h8, 32'(i), 4'hF, 0, 0, 0, r);
    end
    axi_read(4'hC, 0, d, r);
    checks++;
    if (d !== 32'h07FF0000 || r !== OK || n_low !== e_low) begin
      errors++;
      $display("FAIL saturation: got %h/%b pulses %0d/%0d expected 07FF0000/00", d, r, n_low, e_low);
    end
  endtask

  task automatic test_protocol();
    checks++;
    if (timeouts !== 0 || bad_ready !== 0 || extra_b !== 0 || hold_bad !== 0) begin
      errors++;
      $display("FAIL protocol: timeouts %0d ready_while_bvalid %0d extra_b %0d rdata_unstable %0d expected all 0",
               timeouts, bad_ready, extra_b, hold_bad);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    s_axil_awaddr = '0; s_axil_awvalid = 1'b0;
    s_axil_wdata = '0; s_axil_wstrb = '0; s_axil_wvalid = 1'b0;
    s_axil_bready = 1'b0;
    s_axil_araddr = '0; s_axil_arvalid = 1'b0; s_axil_rready = 1'b0;
    running = 1'b0;
    test_reset();
    test_basic_load();
    test_w_before_aw();
    test_control_start();
    test_slverr();
    test_reset_mid_write();
    test_readback();
    test_random();
    test_saturation();
    test_protocol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
